// File: rtl/cmp_result_display_pkg.sv
// Shared constants and font helpers for the comparison result display.
// Holds mode encodings, segment patterns and the hex / letter lookups.
package cmp_disp_pkg;

    localparam logic [1:0] MODE_EQ  = 2'b00;
    localparam logic [1:0] MODE_GT  = 2'b01;
    localparam logic [1:0] MODE_LT  = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_G     = 7'h42;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_H     = 7'h09;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] mode_letter(input logic [1:0] m);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (m)
            MODE_EQ:  s = SEG_E;
            MODE_GT:  s = SEG_G;
            MODE_LT:  s = SEG_L;
            MODE_MAX: s = SEG_H;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cmp_result_display_hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
// Ports: nib = hex digit in, seg = {g,f,e,d,c,b,a} active-low out.
module hex_to_seg7
    import cmp_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_font(nib);

endmodule

// File: rtl/cmp_result_display.sv
// Stability filter, snapshot and 4-digit scanner for the compare result.
// Ports: clk, rst_n, f/sw/hold in; seg/an/dp (active-low), updated out.
module cmp_result_display
    import cmp_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] f,
    input  logic [1:0] sw,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       updated
);

    localparam int SW_W = $clog2(STABLE_CYCLES);
    localparam int RW_W = $clog2(REFRESH_DIV);

    localparam logic [SW_W-1:0] S_MAX = SW_W'(STABLE_CYCLES - 1);
    localparam logic [RW_W-1:0] R_MAX = RW_W'(REFRESH_DIV - 1);

    logic [9:0]      din;
    logic [9:0]      cand;
    logic [9:0]      snap;
    logic [SW_W-1:0] stable_cnt;
    logic            load;

    logic [RW_W-1:0] rcnt;
    logic [1:0]      idx;

    logic [6:0]      seg_lo;
    logic [6:0]      seg_hi;
    logic [6:0]      seg_nxt;
    logic            dp_nxt;

    assign din  = {sw, f};
    assign load = (stable_cnt == S_MAX) && !hold;

    // Filter and snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '0;
            stable_cnt <= '0;
            snap       <= '0;
            updated    <= 1'b0;
        end else begin
            cand <= din;
            if (din != cand) begin
                stable_cnt <= '0;
            end else if (stable_cnt != S_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            // Saturated count reloads every cycle; only a real change pulses
            updated <= load && (cand != snap);
            if (load) begin
                snap <= cand;
            end
        end
    end

    // Scan timing, independent of the filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == R_MAX) begin
            rcnt <= '0;
            idx  <= idx + 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // First cycle of each slot is dark while seg/dp catch up to idx
    always_comb begin
        an = 4'hF;
        if (rcnt != '0) begin
            an = ~(4'b0001 << idx);
        end
    end

    hex_to_seg7 u_lo (
        .nib (snap[3:0]),
        .seg (seg_lo)
    );

    hex_to_seg7 u_hi (
        .nib (snap[7:4]),
        .seg (seg_hi)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        unique case (1'b1)
            (idx == 2'd3): begin
                seg_nxt = mode_letter(snap[9:8]);
                dp_nxt  = !((snap[9:8] == MODE_MAX)
                          && (snap[7:0] == 8'h00));
            end
            (idx == 2'd2): begin
                seg_nxt = SEG_BLANK;
            end
            (idx == 2'd1): begin
                seg_nxt = (snap[7:4] == 4'h0) ? SEG_BLANK : seg_hi;
            end
            (idx == 2'd0): begin
                seg_nxt = seg_lo;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_cmp_result_display.sv
// Directed bench for cmp_result_display with small refresh/stable params.
// Checks reset, filter timing, hold, scan order, dp and async reset.
module tb_cmp_result_display;

    logic       clk;
    logic       rst_n;
    logic [7:0] f;
    logic [1:0] sw;
    logic       hold;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       updated;

    int n_cmp;
    int n_bad;

    cmp_result_display #(
        .REFRESH_DIV   (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f       (f),
        .sw      (sw),
        .hold    (hold),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .updated (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for digit d to be enabled, then samples one cycle into the slot
    task automatic wait_digit(input int d, output logic [6:0] s,
                              output logic p, output bit ok);
        logic [3:0] tgt;
        tgt = 4'b0001 << d;
        tgt = ~tgt;
        ok = 1'b0;
        s = 7'h00;
        p = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == tgt) begin
                @(negedge clk);
                s = seg;
                p = dp;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] s;
        logic p;
        bit ok;
        int pulses;
        rst_n = 1'b0;
        f = 8'h00;
        sw = 2'b00;
        hold = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_an got %h want F", an);
        end
        n_cmp++;
        if (seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL reset_seg got %h want 7F", seg);
        end
        n_cmp++;
        if (dp !== 1'b1 || updated !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dp_upd got %b%b want 10", dp, updated);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (updated === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL reset_no_upd got %0d want 0", pulses);
        end
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h06) begin
            n_bad++;
            $display("FAIL reset_d3 got %h ok=%0d want 06", s, ok);
        end
        wait_digit(1, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h7F) begin
            n_bad++;
            $display("FAIL reset_d1 got %h ok=%0d want 7F", s, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h40) begin
            n_bad++;
            $display("FAIL reset_d0 got %h ok=%0d want 40", s, ok);
        end
    endtask

    task automatic test_max_c();
        logic [6:0] s;
        logic p;
        bit ok;
        @(posedge clk);
        #1;
        sw = 2'b11;
        f = 8'h0C;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (updated !== 1'(k == 4)) begin
                n_bad++;
                $display("FAIL maxc_upd_edge%0d got %b want %b",
                         k, updated, (k == 4));
            end
        end
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h09) begin
            n_bad++;
            $display("FAIL maxc_d3 got %h ok=%0d want 09", s, ok);
        end
        wait_digit(1, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h7F) begin
            n_bad++;
            $display("FAIL maxc_d1 got %h ok=%0d want 7F", s, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h46) begin
            n_bad++;
            $display("FAIL maxc_d0 got %h ok=%0d want 46", s, ok);
        end
    endtask

    task automatic test_toggle();
        logic [6:0] s;
        logic p;
        bit ok;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            sw = 2'b00;
            f = (i % 2 == 0) ? 8'h01 : 8'h00;
            @(negedge clk);
            if (updated === 1'b1) pulses++;
            @(negedge clk);
            if (updated === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL toggle_no_load got %0d want 0", pulses);
        end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (updated === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL toggle_settle got %0d want 1", pulses);
        end
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h06) begin
            n_bad++;
            $display("FAIL toggle_d3 got %h ok=%0d want 06", s, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h40) begin
            n_bad++;
            $display("FAIL toggle_d0 got %h ok=%0d want 40", s, ok);
        end
    endtask

    task automatic test_hold();
        logic [6:0] s;
        logic p;
        bit ok;
        int pulses;
        @(posedge clk);
        #1;
        hold = 1'b1;
        sw = 2'b01;
        f = 8'h01;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (updated === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL hold_no_load got %0d want 0", pulses);
        end
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h06) begin
            n_bad++;
            $display("FAIL hold_frozen_d3 got %h ok=%0d want 06", s, ok);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (updated !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release_upd got %b want 1", updated);
        end
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h42) begin
            n_bad++;
            $display("FAIL hold_d3 got %h ok=%0d want 42", s, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h79) begin
            n_bad++;
            $display("FAIL hold_d0 got %h ok=%0d want 79", s, ok);
        end
    endtask

    task automatic test_hex();
        logic [6:0] s;
        logic p;
        bit ok;
        @(posedge clk);
        #1;
        sw = 2'b10;
        f = 8'hA5;
        repeat (8) @(negedge clk);
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h47) begin
            n_bad++;
            $display("FAIL hex_d3 got %h ok=%0d want 47", s, ok);
        end
        wait_digit(2, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h7F) begin
            n_bad++;
            $display("FAIL hex_d2 got %h ok=%0d want 7F", s, ok);
        end
        wait_digit(1, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h08) begin
            n_bad++;
            $display("FAIL hex_d1 got %h ok=%0d want 08", s, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h12) begin
            n_bad++;
            $display("FAIL hex_d0 got %h ok=%0d want 12", s, ok);
        end
    endtask

    task automatic test_scan();
        bit seen7;
        bit synced;
        logic [3:0] exp_an;
        seen7 = 1'b0;
        synced = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == 4'h7) seen7 = 1'b1;
            else if (seen7 && an == 4'hF) begin
                synced = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!synced) begin
            n_bad++;
            $display("FAIL scan_sync got timeout want an 7->F");
        end
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 4 == 0) exp_an = 4'hF;
            else begin
                exp_an = 4'b0001 << ((c / 4) % 4);
                exp_an = ~exp_an;
            end
            n_cmp++;
            if (an !== exp_an) begin
                n_bad++;
                $display("FAIL scan_an_c%0d got %h want %h", c, an, exp_an);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL scan_onehot_c%0d got %h want <=1 low", c, an);
            end
        end
    endtask

    task automatic test_dp();
        logic [6:0] s;
        logic p;
        bit ok;
        int bad;
        @(posedge clk);
        #1;
        sw = 2'b11;
        f = 8'h00;
        repeat (8) @(negedge clk);
        wait_digit(3, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h09 || p !== 1'b0) begin
            n_bad++;
            $display("FAIL dp_d3 got seg=%h dp=%b ok=%0d want 09/0",
                     s, p, ok);
        end
        wait_digit(0, s, p, ok);
        n_cmp++;
        if (!ok || s !== 7'h40 || p !== 1'b1) begin
            n_bad++;
            $display("FAIL dp_d0 got seg=%h dp=%b ok=%0d want 40/1",
                     s, p, ok);
        end
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (an == 4'h7 && dp !== 1'b0) bad++;
            if (an != 4'h7 && an != 4'hF && dp !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL dp_scan got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rstmid_slot got timeout want an active");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL rstmid_blank got an=%h seg=%h want F/7F",
                     an, seg);
        end
        n_cmp++;
        if (dp !== 1'b1 || updated !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_dp_upd got %b%b want 10", dp, updated);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || an !== 4'hE) begin
            n_bad++;
            $display("FAIL rstmid_restart got an=%h ok=%0d want E", an, ok);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        f = 8'h00;
        sw = 2'b00;
        hold = 1'b0;
        test_reset();
        test_max_c();
        test_toggle();
        test_hold();
        test_hex();
        test_scan();
        test_dp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
